// File: rtl/adder_pkg.sv
// Shared definitions for the sequential slice adder.
//   SLICE_W : width of the shared ripple slice
//   state_t : controller states IDLE / RUN / DONE
//   nslice  : number of slice passes needed for a given operand width
package adder_pkg;

  localparam int SLICE_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int nslice(input int width);
    return (width + SLICE_W - 1) / SLICE_W;
  endfunction

endpackage

// File: rtl/adder_slice3.sv
// Purely combinational 3-bit ripple-carry adder slice.
// Ports:
//   a, b : 3-bit operands
//   ci   : carry in
//   s    : 3-bit sum
//   co   : carry out of bit 2
module adder_slice3 (
  input  logic [2:0] a,
  input  logic [2:0] b,
  input  logic       ci,
  output logic [2:0] s,
  output logic       co
);

  logic [3:0] w_c;

  always_comb begin
    w_c    = '0;
    s      = '0;
    w_c[0] = ci;
    for (int i = 0; i < 3; i++) begin
      s[i]     = a[i] ^ b[i] ^ w_c[i];
      w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end
  end

  assign co = w_c[3];

endmodule

// File: rtl/adder_seq_ctrl.sv
// Sequencing controller: computes one WIDTH-bit add a + b + cin by passing
// 3-bit chunks, LSB first, through a single shared adder_slice3, one chunk
// per clock, with the slice carry registered between passes.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready depends only on state; out_valid holds, with sum/cout
// stable, until out_ready is seen. No input reaches any output combinationally.
//
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : operand handshake (a, b, cin)
//   out_valid / out_ready: result handshake (sum, cout)
//   busy                 : high while slices are being processed
//   slice_idx            : slice being processed, 0 outside RUN
//   dbg_state            : current FSM state for observation
module adder_seq_ctrl
  import adder_pkg::*;
#(
  parameter  int WIDTH  = 18,
  localparam int NSLICE = nslice(WIDTH),
  localparam int IDXW   = $clog2(NSLICE) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic [IDXW-1:0]  slice_idx,
  output state_t           dbg_state
);

  localparam int PADW = NSLICE * SLICE_W;
  localparam int REM  = WIDTH % SLICE_W;

  state_t           r_state;
  state_t           w_next;
  logic [PADW-1:0]  r_a;
  logic [PADW-1:0]  r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_carry;
  logic             r_cout;
  logic [IDXW-1:0]  r_idx;

  logic [2:0]       w_sa;
  logic [2:0]       w_sb;
  logic [2:0]       w_ss;
  logic             w_sco;
  logic             w_last;
  logic             w_top_carry;

  // Operands are stored zero-padded to a whole number of slices so the top
  // chunk can be selected like any other.
  assign w_sa   = r_a[SLICE_W*r_idx +: SLICE_W];
  assign w_sb   = r_b[SLICE_W*r_idx +: SLICE_W];
  assign w_last = (r_idx == IDXW'(NSLICE - 1));

  adder_slice3 u_slice (
    .a  (w_sa),
    .b  (w_sb),
    .ci (r_carry),
    .s  (w_ss),
    .co (w_sco)
  );

  // Carry out of bit WIDTH-1. With zero padding in the top slice, the carry
  // into the first padded bit shows up as that padded sum bit.
  generate
    if (REM == 0) begin : g_full_top
      assign w_top_carry = w_sco;
    end else begin : g_pad_top
      assign w_top_carry = w_ss[REM];
    end
  endgenerate

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_next = RUN;
      RUN:     if (w_last) w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Output decode, from state and registers only
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    slice_idx = '0;
    case (r_state)
      IDLE: in_ready = 1'b1;
      RUN: begin
        busy      = 1'b1;
        slice_idx = r_idx;
      end
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  assign sum       = r_res;
  assign cout      = r_cout;
  assign dbg_state = r_state;

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= PADW'(a);
            r_b     <= PADW'(b);
            r_carry <= cin;
            r_res   <= '0;
            r_cout  <= 1'b0;
            r_idx   <= '0;
          end
        end
        RUN: begin
          // Padded sum bits above WIDTH-1 are dropped here.
          for (int k = 0; k < SLICE_W; k++) begin
            if (SLICE_W * int'(r_idx) + k < WIDTH)
              r_res[SLICE_W*int'(r_idx)+k] <= w_ss[k];
          end
          r_carry <= w_sco;
          if (w_last) begin
            r_cout <= w_top_carry;
            // Parked at 0 so the slice select never points past the operands.
            r_idx  <= '0;
          end else begin
            r_idx  <= r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/adder_seq_ctrl.md
Name: adder_seq_ctrl

Overview:
- Sequencing controller that computes one WIDTH-bit add using a single shared 3-bit ripple adder slice (3-bit a/b, carry-in, 3-bit sum, carry-out).
- Each cycle it feeds the next 3-bit operand chunk to the slice, LSB chunk first, and registers the slice carry into the next chunk.
- It sits between a valid/ready producer and consumer, and trades latency for area in approximate-adder partition experiments.

Parameters:
- WIDTH, 18, operand/sum width in bits; any value >= 1.
- NSLICE, ceil(WIDTH/3) (derived localparam, not overridable), number of slice passes per add.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, synchronous to clk, active-high.
- in_valid  input  1  operands and carry-in are valid.
- in_ready  output  1  controller can accept an operation.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in for the LSB slice.
- out_valid  output  1  result is available.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  a + b + cin, modulo 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.
- busy  output  1  high in RUN state.
- slice_idx  output  clog2(NSLICE)+1  index of the slice being processed; 0 when not in RUN.

Behaviour:
- States: IDLE, RUN, DONE. Reset (rst=1 at a clk edge) forces IDLE. Reset values: out_valid=0, sum=0, cout=0, busy=0, slice_idx=0; carry, operand and index registers are cleared. in_ready=1 in the first cycle after rst deasserts.
- in_ready = (state==IDLE), decoded combinationally from state only. out_valid = (state==DONE).
- IDLE: on in_valid & in_ready at an edge, latch a, b and cin into the carry register, set idx=0, and go to RUN. The result register is cleared on accept.
- RUN: each edge,
  - drive the slice with a[3*idx+:3], b[3*idx+:3] and carry;
  - write the slice sum into result bits [3*idx+:3];
  - load carry with the slice cout;
  - increment idx.
- RUN exit: the edge that processes idx==NSLICE-1 moves to DONE.
- Latency: with the accept on edge E0, out_valid is high from just after edge E0+NSLICE. WIDTH=18 gives 6 cycles.
- Top slice when WIDTH%3 != 0: operand bits above WIDTH-1 are zero-padded and the padded sum bits are discarded.
  - cout is the carry out of bit WIDTH-1, not the slice cout. Take it from the internal ripple at that bit position, i.e. the carry into the first padded bit.
  - For the zero-padded top slice this equals the padded slice-sum bit at position WIDTH%3. Implement it that way.
- DONE: sum and cout hold stable while out_valid=1 and out_ready=0. On out_valid & out_ready, go to IDLE. A new accept is not possible in the same cycle.
- in_valid while in RUN or DONE is ignored (in_ready=0). Operand changes after accept have no effect.
- Reset mid-operation: abort. Return to IDLE at the next edge and discard the partial result; out_valid is never asserted for the aborted op.
- No combinational path from in_valid or out_ready to any output.

Decomposition:
- Shared package adder_pkg holds:
  - SLICE_W=3;
  - a state enum type {IDLE, RUN, DONE};
  - a function nslice(width) returning ceil(width/SLICE_W).
- One sub-module, adder_slice3: purely combinational 3-bit ripple adder.
  - Inputs a[2:0], b[2:0], ci.
  - Outputs s[2:0], co.
  - Instantiated once inside adder_seq_ctrl.

Test Plan:
- WIDTH=18, a=0x3FFFF, b=0x00001, cin=0 -> sum=0x00000, cout=1; out_valid rises 6 cycles after accept.
- WIDTH=18, a=0x12345, b=0x0ABCD, cin=1 -> sum=0x1CF13, cout=0; slice_idx steps 0..5 while busy=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> sum and cout stable, in_ready=0 throughout. Then out_ready=1 -> IDLE and in_ready=1 next cycle.
- Assert rst for 1 cycle while slice_idx==3 -> next cycle IDLE, out_valid=0, sum=0. A following op a=1, b=2, cin=0 -> sum=3, cout=0.
- in_valid pulsed with a=0x3FFFF during RUN of op a=5, b=7 -> result sum=12, cout=0; the second op is not accepted.
- WIDTH=8 (NSLICE=3, 1 pad bit):
  - a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1.
  - a=0x7F, b=0x01 -> sum=0x80, cout=0.
